// File: rtl/fir_pkg.sv
// Shared definitions for the subtract scheduler: output FSM encoding and the
// tag-width helper used to size requester indices.
package fir_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Requester index width, never narrower than one bit.
    function automatic int tag_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/n_bit_csa_subtractor.sv
// Carry-select subtractor: in1 - in2 on sign-extended two's-complement operands,
// low half ripples while the high half is precomputed for both carry-in values.
module n_bit_csa_subtractor #(
    parameter int IN_W  = 8,
    parameter int OUT_W = IN_W + 1
) (
    input  logic [IN_W-1:0]  in1,
    input  logic [IN_W-1:0]  in2,
    output logic [OUT_W-1:0] diff
);

    localparam int LO_W = OUT_W / 2;
    localparam int HI_W = OUT_W - LO_W;

    logic [OUT_W-1:0] a_ext;
    logic [OUT_W-1:0] b_inv;
    logic [LO_W:0]    lo_sum;
    logic [HI_W-1:0]  hi_sum0;
    logic [HI_W-1:0]  hi_sum1;

    // Subtraction as a + ~b + 1, with the +1 entering at the low-half carry-in.
    assign a_ext = OUT_W'($signed(in1));
    assign b_inv = ~(OUT_W'($signed(in2)));

    assign lo_sum  = {1'b0, a_ext[LO_W-1:0]} + {1'b0, b_inv[LO_W-1:0]} + (LO_W+1)'(1);
    assign hi_sum0 = a_ext[OUT_W-1:LO_W] + b_inv[OUT_W-1:LO_W];
    assign hi_sum1 = a_ext[OUT_W-1:LO_W] + b_inv[OUT_W-1:LO_W] + HI_W'(1);

    assign diff = {(lo_sum[LO_W] ? hi_sum1 : hi_sum0), lo_sum[LO_W-1:0]};

endmodule

// File: rtl/csa_sub_scheduler.sv
// Round-robin scheduler sharing one subtractor among NUM_REQ requesters, with a
// single-entry registered result stage that sustains one result per cycle.
module csa_sub_scheduler
    import fir_pkg::*;
#(
    parameter int IN_DATAWIDTH  = 8,
    parameter int OUT_DATAWIDTH = IN_DATAWIDTH + 1,
    parameter int NUM_REQ       = 4,
    localparam int TAG_W        = tag_width(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*IN_DATAWIDTH-1:0] req_in1,
    input  logic [NUM_REQ*IN_DATAWIDTH-1:0] req_in2,
    output logic                            res_valid,
    input  logic                            res_ready,
    output logic [OUT_DATAWIDTH-1:0]        res_data,
    output logic [TAG_W-1:0]                res_tag
);

    state_t                   state_reg;
    logic [OUT_DATAWIDTH-1:0] res_data_reg;
    logic [TAG_W-1:0]         res_tag_reg;
    logic [TAG_W-1:0]         rr_ptr_reg;
    logic [TAG_W-1:0]         rr_ptr_next;

    logic                     grant_valid;
    logic [TAG_W-1:0]         grant_idx;
    logic                     can_accept;
    logic                     transfer;
    logic [IN_DATAWIDTH-1:0]  in1_sel;
    logic [IN_DATAWIDTH-1:0]  in2_sel;
    logic [OUT_DATAWIDTH-1:0] diff;

    // First valid requester at or after rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = int'(rr_ptr_reg) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_valid && req_valid[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = TAG_W'(idx);
            end
        end
    end

    assign can_accept = !res_valid || res_ready;
    assign transfer   = grant_valid && can_accept && !rst;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = transfer && (grant_idx == TAG_W'(gi));
        end
    endgenerate

    assign in1_sel = req_in1[grant_idx*IN_DATAWIDTH +: IN_DATAWIDTH];
    assign in2_sel = req_in2[grant_idx*IN_DATAWIDTH +: IN_DATAWIDTH];

    n_bit_csa_subtractor #(
        .IN_W  (IN_DATAWIDTH),
        .OUT_W (OUT_DATAWIDTH)
    ) u_sub (
        .in1  (in1_sel),
        .in2  (in2_sel),
        .diff (diff)
    );

    assign rr_ptr_next = (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + TAG_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= EMPTY;
            res_data_reg <= '0;
            res_tag_reg  <= '0;
            rr_ptr_reg   <= '0;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (transfer) begin
                        state_reg <= FULL;
                    end
                end
                FULL: begin
                    if (res_ready && !transfer) begin
                        state_reg <= EMPTY;
                    end
                end
                default: state_reg <= EMPTY;
            endcase
            if (transfer) begin
                res_data_reg <= diff;
                res_tag_reg  <= grant_idx;
                rr_ptr_reg   <= rr_ptr_next;
            end
        end
    end

    assign res_valid = (state_reg == FULL);
    assign res_data  = res_data_reg;
    assign res_tag   = res_tag_reg;

endmodule

// File: tb/tb_csa_sub_scheduler.sv
// Directed bench for csa_sub_scheduler: a vector table for single transfers plus
// hand sequences for round-robin rotation, backpressure, reset and sparse requests.
module tb_csa_sub_scheduler;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_in1;
    logic [31:0] req_in2;
    logic        res_valid;
    logic        res_ready;
    logic [8:0]  res_data;
    logic [1:0]  res_tag;

    int n_total = 0;
    int n_pass  = 0;

    csa_sub_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_in1   (req_in1),
        .req_in2   (req_in2),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_tag   (res_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rv;
        logic [31:0] in1;
        logic [31:0] in2;
        logic        rdy;
        logic [3:0]  exp_ready;
        logic        exp_valid;
        logic [8:0]  exp_data;
        logic [1:0]  exp_tag;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Ungranted slots carry junk so a wrong operand mux shows up in res_data.
        vecs[0] = '{4'b0001, 32'hAABBCC05, 32'h11223303, 1'b1, 4'b0001, 1'b1, 9'h002, 2'd0};
        vecs[1] = '{4'b0100, 32'hAA00CCDD, 32'h11013344, 1'b1, 4'b0100, 1'b1, 9'h1FF, 2'd2};
        vecs[2] = '{4'b0100, 32'h12803456, 32'h9A7FBCDE, 1'b1, 4'b0100, 1'b1, 9'h101, 2'd2};
        vecs[3] = '{4'b0010, 32'h55667F77, 32'h889980AA, 1'b1, 4'b0010, 1'b1, 9'h0FF, 2'd1};
        vecs[4] = '{4'b1000, 32'h80112233, 32'h80445566, 1'b1, 4'b1000, 1'b1, 9'h000, 2'd3};
        vecs[5] = '{4'b0000, 32'h01020304, 32'h05060708, 1'b1, 4'b0000, 1'b0, 9'h000, 2'd3};
        vecs[6] = '{4'b0001, 32'h010203FF, 32'h04050601, 1'b1, 4'b0001, 1'b1, 9'h1FE, 2'd0};
        vecs[7] = '{4'b1001, 32'h0110207F, 32'hFF304000, 1'b1, 4'b1000, 1'b1, 9'h002, 2'd3};

        rst       = 1'b1;
        req_valid = 4'b1111;
        req_in1   = '0;
        req_in2   = '0;
        res_ready = 1'b1;
        tick();
        check("reset_req_ready", 32'(req_ready), 32'h0);
        tick();
        check("reset_res_valid", 32'(res_valid), 32'h0);
        check("reset_res_data", 32'(res_data), 32'h0);
        check("reset_res_tag", 32'(res_tag), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            req_valid = vecs[i].rv;
            req_in1   = vecs[i].in1;
            req_in2   = vecs[i].in2;
            res_ready = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_res_valid", i), 32'(res_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_res_data", i), 32'(res_data), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_res_tag", i), 32'(res_tag), 32'(vecs[i].exp_tag));
            $display("vec %0d: rv=%b valid=%0d data=%h tag=%0d", i, vecs[i].rv, res_valid, res_data, res_tag);
        end

        // All requesting, no backpressure: strict rotation 0,1,2,3,0 with no bubbles.
        req_valid = 4'b1111;
        req_in1   = 32'h04030201;
        req_in2   = 32'h00000000;
        res_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("rr%0d_res_valid", k), 32'(res_valid), 32'h1);
            check($sformatf("rr%0d_res_tag", k), 32'(res_tag), 32'(k % 4));
            check($sformatf("rr%0d_res_data", k), 32'(res_data), 32'((k % 4) + 1));
            $display("rr %0d: tag=%0d data=%h", k, res_tag, res_data);
        end

        // Backpressure for 3 cycles: result held, nobody accepted.
        res_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("stall%0d_req_ready", k), 32'(req_ready), 32'h0);
            tick();
            check($sformatf("stall%0d_res_valid", k), 32'(res_valid), 32'h1);
            check($sformatf("stall%0d_res_tag", k), 32'(res_tag), 32'h0);
            check($sformatf("stall%0d_res_data", k), 32'(res_data), 32'h001);
            $display("stall %0d: tag=%0d data=%h", k, res_tag, res_data);
        end
        res_ready = 1'b1;
        #1;
        check("unstall_req_ready", 32'(req_ready), 32'b0010);
        tick();
        check("unstall_res_tag", 32'(res_tag), 32'h1);
        check("unstall_res_data", 32'(res_data), 32'h002);
        $display("unstall: tag=%0d data=%h", res_tag, res_data);

        // Reset while FULL with a pending result and requester 3 waiting.
        res_ready = 1'b0;
        req_valid = 4'b1000;
        rst       = 1'b1;
        #1;
        check("rstfull_req_ready", 32'(req_ready), 32'h0);
        tick();
        check("rstfull_res_valid", 32'(res_valid), 32'h0);
        check("rstfull_res_data", 32'(res_data), 32'h0);
        check("rstfull_res_tag", 32'(res_tag), 32'h0);
        rst       = 1'b0;
        res_ready = 1'b1;
        #1;
        check("postrst_req_ready", 32'(req_ready), 32'b1000);
        tick();
        check("postrst_res_valid", 32'(res_valid), 32'h1);
        check("postrst_res_tag", 32'(res_tag), 32'h3);
        check("postrst_res_data", 32'(res_data), 32'h004);
        $display("post reset: tag=%0d data=%h", res_tag, res_data);

        // Sparse requests: grants alternate between the two active requesters.
        req_valid = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("sparse%0d_res_tag", k), 32'(res_tag), (k % 2 == 0) ? 32'h0 : 32'h2);
            check($sformatf("sparse%0d_res_data", k), 32'(res_data), (k % 2 == 0) ? 32'h001 : 32'h003);
            $display("sparse %0d: tag=%0d data=%h", k, res_tag, res_data);
        end

        // Pointer was at 3; reset must bring the search start back to 0.
        rst       = 1'b1;
        req_valid = 4'b1111;
        tick();
        rst = 1'b0;
        tick();
        check("ptrrst_res_tag", 32'(res_tag), 32'h0);
        check("ptrrst_res_valid", 32'(res_valid), 32'h1);
        $display("pointer reset: tag=%0d data=%h", res_tag, res_data);

        // Drain: result consumed, outputs keep their last values.
        req_valid = 4'b0000;
        tick();
        check("drain_res_valid", 32'(res_valid), 32'h0);
        check("drain_res_tag", 32'(res_tag), 32'h0);
        check("drain_res_data", 32'(res_data), 32'h001);
        $display("drain: valid=%0d tag=%0d data=%h", res_valid, res_tag, res_data);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
